// File: rtl/frame_grabber_if.sv
// VRAM pixel write port between the frame grabber (master) and pixel memory (slave).
interface frame_grabber_if #(
    parameter int ADDR_W = 17
) ();
    logic [ADDR_W-1:0] vramPX_addr;
    logic [7:0]        vramPX_d;
    logic              vramPX_we;

    modport master (output vramPX_addr, output vramPX_d, output vramPX_we);
    modport slave  (input  vramPX_addr, input  vramPX_d, input  vramPX_we);
endinterface

// File: rtl/frame_grabber.sv
// Captures an RGB24 stream, decimates 2:1 in both axes and writes R3G3B2 pixels into VRAM.
// Define FRAME_GRABBER_ROUND_EN for rounding/saturating colour conversion instead of truncation.
module frame_grabber #(
    parameter int ACT_W  = 640,
    parameter int ACT_H  = 480,
    parameter int ADDR_W = 17
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [7:0]      vid_r,
    input  logic [7:0]      vid_g,
    input  logic [7:0]      vid_b,
    input  logic            vid_hs,
    input  logic            vid_vs,
    input  logic            vid_blank,
    input  logic            arm,
    input  logic            abort,
    input  logic            continuous,
    frame_grabber_if.master vram,
    output logic            busy,
    output logic            frameCaptured,
    output logic            shortFrame
);
    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    localparam logic [9:0]        X_END     = 10'(ACT_W);
    localparam logic [8:0]        Y_END     = 9'(ACT_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((ACT_W / 2) * (ACT_H / 2) - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            next_state;
    logic              vs_prev;
    logic              vs_fall;
    logic [9:0]        x;
    logic [8:0]        y;
    logic              line_active;
    logic [ADDR_W-1:0] wr_addr;
    logic              start_capture;
    logic              restart;
    logic              pixel_active;
    logic              write_issue;
    logic [7:0]        pixel_rgb;
    logic              unused_bits;

    assign vs_fall = vs_prev & ~vid_vs;

`ifdef FRAME_GRABBER_ROUND_EN
    logic [8:0] r_sum;
    logic [8:0] g_sum;
    logic [8:0] b_sum;

    // Bit 8 of each sum marks an overflow past the top code, which saturates.
    always_comb begin
        r_sum     = {1'b0, vid_r} + 9'd16;
        g_sum     = {1'b0, vid_g} + 9'd16;
        b_sum     = {1'b0, vid_b} + 9'd32;
        pixel_rgb = {r_sum[8] ? 3'd7 : r_sum[7:5],
                     g_sum[8] ? 3'd7 : g_sum[7:5],
                     b_sum[8] ? 2'd3 : b_sum[7:6]};
    end

    assign unused_bits = &{1'b0, vid_hs, r_sum[4:0], g_sum[4:0], b_sum[5:0]};
`else
    assign pixel_rgb   = {vid_r[7:5], vid_g[7:5], vid_b[7:6]};
    assign unused_bits = &{1'b0, vid_hs, vid_r[4:0], vid_g[4:0], vid_b[5:0]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arm) next_state = WAIT_VS;
            WAIT_VS: begin
                if (abort)        next_state = IDLE;
                else if (vs_fall) next_state = CAPTURE;
            end
            CAPTURE: begin
                if (abort)        next_state = IDLE;
                else if (vs_fall) next_state = CAPTURE;
                else if (write_issue && wr_addr == LAST_ADDR) next_state = DONE;
            end
            DONE:    next_state = continuous ? WAIT_VS : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Abort outranks vsync, and vsync outranks pixel writes on the same edge.
    always_comb begin
        busy          = (state != IDLE);
        frameCaptured = (state == DONE);
        start_capture = 1'b0;
        restart       = 1'b0;
        pixel_active  = 1'b0;
        write_issue   = 1'b0;
        if (!abort && vs_fall) begin
            start_capture = (state == WAIT_VS) || (state == CAPTURE);
            restart       = (state == CAPTURE);
        end
        if (state == CAPTURE && !abort && !vs_fall && !vid_blank) begin
            pixel_active = 1'b1;
            write_issue  = (x < X_END) && !x[0] && !y[0] && (y < Y_END);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev          <= 1'b1;
            x                <= '0;
            y                <= '0;
            line_active      <= 1'b0;
            wr_addr          <= '0;
            vram.vramPX_we   <= 1'b0;
            vram.vramPX_addr <= '0;
            vram.vramPX_d    <= '0;
        end else begin
            vs_prev        <= vid_vs;
            vram.vramPX_we <= write_issue;
            if (write_issue) begin
                vram.vramPX_addr <= wr_addr;
                vram.vramPX_d    <= pixel_rgb;
                wr_addr          <= wr_addr + ADDR_ONE;
            end
            if (start_capture) begin
                x           <= '0;
                y           <= '0;
                line_active <= 1'b0;
                wr_addr     <= '0;
            end else if (pixel_active) begin
                if (x < X_END) x <= x + 10'd1;
                line_active <= 1'b1;
            end else if (state == CAPTURE && vid_blank && line_active) begin
                if (y < Y_END) y <= y + 9'd1;
                x           <= '0;
                line_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shortFrame <= 1'b0;
        end else if (state == IDLE && arm) begin
            shortFrame <= 1'b0;
        end else if (restart) begin
            shortFrame <= 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_grabber.sv
// Directed self-checking bench for frame_grabber on a scaled 16x12 source (8x6 = 48 VRAM pixels).
`timescale 1ns/1ps
module tb_frame_grabber;
    localparam int ACT_W  = 16;
    localparam int ACT_H  = 12;
    localparam int ADDR_W = 17;
    localparam int NPIX   = (ACT_W / 2) * (ACT_H / 2);

`ifdef FRAME_GRABBER_ROUND_EN
    localparam logic [7:0] CONST_R   = 8'hF0;
    localparam logic [7:0] CONST_G   = 8'h90;
    localparam logic [7:0] CONST_B   = 8'hA0;
    localparam logic [7:0] EXP_CONST = 8'b111_101_11;
    localparam logic [7:0] EXP_A9    = 8'h25;
    localparam logic [7:0] EXP_A20   = 8'h8E;
`else
    localparam logic [7:0] CONST_R   = 8'hFF;
    localparam logic [7:0] CONST_G   = 8'h80;
    localparam logic [7:0] CONST_B   = 8'h7F;
    localparam logic [7:0] EXP_CONST = 8'b111_100_01;
    localparam logic [7:0] EXP_A9    = 8'h24;
    localparam logic [7:0] EXP_A20   = 8'h89;
`endif
    localparam logic [7:0] EXP_A0  = 8'h00;
    localparam logic [7:0] EXP_A47 = 8'hFB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] vid_r, vid_g, vid_b;
    logic       vid_hs, vid_vs, vid_blank;
    logic       arm, abort, continuous;
    logic       busy, frameCaptured, shortFrame;

    int checks = 0;
    int passed = 0;
    int writes, addrErrors, pulses, busyDrops, expAddr, monIdx, snap, bad;
    logic monClear, busyWatch;
    logic [7:0] mem [0:NPIX-1];
    int wcount [0:NPIX-1];

    always #5 clk = ~clk;

    frame_grabber_if #(.ADDR_W(ADDR_W)) vram ();

    frame_grabber #(.ACT_W(ACT_W), .ACT_H(ACT_H), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_blank(vid_blank),
        .arm(arm), .abort(abort), .continuous(continuous),
        .vram(vram),
        .busy(busy), .frameCaptured(frameCaptured), .shortFrame(shortFrame)
    );

    // Records every VRAM write and pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (monClear) begin
            writes = 0; addrErrors = 0; pulses = 0; busyDrops = 0; expAddr = 0;
            for (int i = 0; i < NPIX; i++) wcount[i] = 0;
        end else begin
            if (vram.vramPX_we) begin
                monIdx = int'(vram.vramPX_addr);
                writes++;
                if (monIdx != expAddr) addrErrors++;
                if (monIdx < NPIX) begin
                    mem[monIdx] = vram.vramPX_d;
                    wcount[monIdx]++;
                end
                expAddr = (monIdx >= NPIX - 1) ? 0 : monIdx + 1;
            end
            if (frameCaptured) pulses++;
            if (busyWatch && !busy) busyDrops++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseArm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pulseAbort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic monClearPulse();
        monClear = 1'b1;
        @(negedge clk);
        #1 monClear = 1'b0;
        tick();
    endtask

    // One frame: vsync pulse, then nLines of blanking+active pixels, then trailing blank.
    task automatic applyStimulus(input int nLines, input bit constMode);
        vid_blank = 1'b1; vid_vs = 1'b1; vid_hs = 1'b1;
        repeat (2) tick();
        vid_vs = 1'b0; repeat (2) tick();
        vid_vs = 1'b1; repeat (2) tick();
        for (int y = 0; y < nLines; y++) begin
            vid_blank = 1'b1;
            vid_hs = 1'b0; repeat (2) tick();
            vid_hs = 1'b1; repeat (2) tick();
            for (int x = 0; x < ACT_W; x++) begin
                vid_blank = 1'b0;
                if (constMode) begin
                    vid_r = CONST_R; vid_g = CONST_G; vid_b = CONST_B;
                end else begin
                    vid_r = 8'(x * 16); vid_g = 8'(y * 20); vid_b = 8'((x + y) * 8);
                end
                tick();
            end
        end
        vid_blank = 1'b1;
        repeat (4) tick();
    endtask

    task automatic waitWrites(input int target, input string tag);
        int n = 0;
        while (writes < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(writes >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vid_r = '0; vid_g = '0; vid_b = '0;
        vid_hs = 1'b1; vid_vs = 1'b1; vid_blank = 1'b1;
        arm = 1'b0; abort = 1'b0; continuous = 1'b0;
        monClear = 1'b1; busyWatch = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_we", vram.vramPX_we, 0);
        checkOutput("rst_addr", vram.vramPX_addr, 0);
        checkOutput("rst_d", vram.vramPX_d, 0);
        checkOutput("rst_fc", frameCaptured, 0);
        checkOutput("rst_sf", shortFrame, 0);
        tick();
        reset_n = 1'b1; monClear = 1'b0;
        tick();

        $display("[TB] full single-shot frame");
        pulseArm();
        checkOutput("arm_busy", busy, 1);
        applyStimulus(ACT_H, 1'b0);
        checkOutput("f1_writes", writes, NPIX);
        checkOutput("f1_addr_seq", addrErrors, 0);
        checkOutput("f1_pulses", pulses, 1);
        checkOutput("f1_busy_after", busy, 0);
        checkOutput("f1_mem0", mem[0], EXP_A0);
        checkOutput("f1_mem9", mem[9], EXP_A9);
        checkOutput("f1_mem20", mem[20], EXP_A20);
        checkOutput("f1_mem47", mem[47], EXP_A47);

        $display("[TB] constant colour frame");
        monClearPulse();
        pulseArm();
        applyStimulus(ACT_H, 1'b1);
        checkOutput("const_mem5", mem[5], EXP_CONST);
        checkOutput("const_mem47", mem[47], EXP_CONST);
        checkOutput("const_pulses", pulses, 1);

        $display("[TB] continuous capture over two frames");
        monClearPulse();
        continuous = 1'b1;
        pulseArm();
        busyWatch = 1'b1;
        applyStimulus(ACT_H, 1'b0);
        applyStimulus(ACT_H, 1'b0);
        busyWatch = 1'b0;
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (wcount[i] != 2) bad++;
        checkOutput("cont_pulses", pulses, 2);
        checkOutput("cont_writes", writes, 2 * NPIX);
        checkOutput("cont_twice", bad, 0);
        checkOutput("cont_addr_seq", addrErrors, 0);
        checkOutput("cont_busy_drops", busyDrops, 0);
        checkOutput("cont_busy_rearm", busy, 1);
        continuous = 1'b0;
        pulseAbort();
        checkOutput("cont_abort_idle", busy, 0);

        $display("[TB] short frame");
        monClearPulse();
        pulseArm();
        applyStimulus(4, 1'b0);
        checkOutput("short_pre_writes", writes, 16);
        checkOutput("short_pre_flag", shortFrame, 0);
        checkOutput("short_pre_pulses", pulses, 0);
        monClearPulse();
        applyStimulus(ACT_H, 1'b0);
        checkOutput("short_flag", shortFrame, 1);
        checkOutput("short_full_writes", writes, NPIX);
        checkOutput("short_full_addr_seq", addrErrors, 0);
        checkOutput("short_full_pulses", pulses, 1);
        checkOutput("short_flag_idle", shortFrame, 1);
        pulseArm();
        checkOutput("short_flag_cleared", shortFrame, 0);
        pulseAbort();

        $display("[TB] abort mid-frame");
        monClearPulse();
        pulseArm();
        fork
            applyStimulus(ACT_H, 1'b0);
            begin
                waitWrites(20, "abort_reach");
                @(posedge clk);
                #1 abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                snap = writes;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_we", vram.vramPX_we, 0);
            end
        join
        checkOutput("abort_no_more_writes", writes, snap);
        checkOutput("abort_pulses", pulses, 0);
        monClearPulse();
        pulseArm();
        applyStimulus(ACT_H, 1'b0);
        checkOutput("rearm_writes", writes, NPIX);
        checkOutput("rearm_addr_seq", addrErrors, 0);
        checkOutput("rearm_pulses", pulses, 1);

        $display("[TB] asynchronous reset mid-line");
        monClearPulse();
        pulseArm();
        fork
            applyStimulus(ACT_H, 1'b0);
            begin
                waitWrites(10, "reset_reach");
                @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                checkOutput("async_rst_busy", busy, 0);
                checkOutput("async_rst_we", vram.vramPX_we, 0);
                checkOutput("async_rst_addr", vram.vramPX_addr, 0);
                checkOutput("async_rst_d", vram.vramPX_d, 0);
                tick();
                reset_n = 1'b1;
            end
        join
        monClearPulse();
        pulseArm();
        vid_vs = 1'b1;
        for (int i = 0; i < 40; i++) begin
            vid_blank = (i % 10) < 3;
            vid_r = 8'hAA; vid_g = 8'h55; vid_b = 8'hCC;
            tick();
        end
        checkOutput("novs_busy", busy, 1);
        checkOutput("novs_writes", writes, 0);
        pulseAbort();
        checkOutput("novs_abort_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/frame_grabber.md
Name: frame_grabber

Overview:
- Video capture engine: the inverse of the frame synthesizer's pixel plane.
- Accepts a parallel RGB24 video stream with hsync, vsync and blank, synchronous to the pixel clock.
- Decimates 640x480 active video 2:1 in each axis, converts each kept pixel to R3G3B2, and writes the 320x240 result linearly into pixel VRAM (addresses 0..76799).
- Armed by the CPU for single-shot or continuous capture; issues a completion pulse for the interrupt controller.

Parameters:
- ACT_W, 640, active pixels per line in the source.
- ACT_H, 480, active lines per frame in the source.
- ADDR_W, 17, pixel VRAM address width.

Ports:
- clk  in  1  pixel clock; all inputs are synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- vid_r  in  8  red.
- vid_g  in  8  green.
- vid_b  in  8  blue.
- vid_hs  in  1  hsync, active low (informational, unused for timing).
- vid_vs  in  1  vsync, active low.
- vid_blank  in  1  1 = blanking, 0 = active pixel.
- arm  in  1  1-cycle pulse: start a capture.
- abort  in  1  1-cycle pulse: cancel the capture.
- continuous  in  1  re-arm automatically after each frame.
- vramPX_addr  out  ADDR_W  write address.
- vramPX_d  out  8  R3G3B2 write data.
- vramPX_we  out  1  write enable.
- busy  out  1  state != IDLE.
- frameCaptured  out  1  1-cycle pulse on completion.
- shortFrame  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State = IDLE.
  - vramPX_we, frameCaptured, shortFrame, busy all 0.
  - vramPX_addr and vramPX_d both 0.
  - vs_prev = 1; counters cleared.
- vs edge: vs_fall = vs_prev & ~vid_vs, where vs_prev is vid_vs registered on every clk.
- IDLE:
  - arm=1 -> WAIT_VS and shortFrame cleared.
  - abort is ignored in IDLE.
- WAIT_VS: vs_fall -> CAPTURE, with x=0, y=0, wr_addr=0, line_active=0.
- CAPTURE, on each cycle with vid_blank=0:
  - If x < ACT_W: x increments. If x[0]=0 and y[0]=0 and y < ACT_H, issue a write.
  - If x >= ACT_W: the pixel is ignored (x holds at ACT_W).
  - line_active is set to 1.
- CAPTURE, on each cycle with vid_blank=1 and line_active=1: y++, x=0, line_active=0.
- Write timing (1-cycle latency): the pixel sampled at edge k drives the following on the outputs after edge k:
  - vramPX_we=1;
  - vramPX_addr = wr_addr;
  - vramPX_d = {r[7:5], g[7:5], b[7:6]}.
  - wr_addr then increments. In all other cycles vramPX_we=0 and addr/data hold their last values.
- Completion:
  - On the edge issuing the write with wr_addr = (ACT_W/2)*(ACT_H/2)-1, the state moves to DONE.
  - DONE lasts one cycle with frameCaptured=1.
  - Then next state: WAIT_VS if continuous=1 (sampled in DONE), else IDLE.
- Short frame:
  - vs_fall while in CAPTURE sets shortFrame=1 and restarts CAPTURE immediately, with counters cleared as in WAIT_VS.
  - No frameCaptured pulse is issued for the short frame.
  - shortFrame stays set until the next arm accepted in IDLE.
- Excess active lines (y >= ACT_H) never write. Capture ends on the write count regardless.
- abort:
  - abort in WAIT_VS or CAPTURE -> IDLE on the next edge.
  - vramPX_we=0 from that edge onward; no frameCaptured pulse.
  - abort has priority over every simultaneous event (vs_fall, final write, arm).
- arm outside IDLE: ignored.
- arm and vs_fall in the same cycle in IDLE: the state goes to WAIT_VS; that edge does not start the capture.
- Reset mid-capture: the capture is abandoned immediately; VRAM contents are undefined beyond the last completed write.
- Widths:
  - x: 10 bits.
  - y: 9 bits; y saturates at ACT_H.
  - wr_addr: ADDR_W bits and never wraps, because completion precedes overflow.

Optional Feature:
- Macro: FRAME_GRABBER_ROUND_EN.
- Defined: rounding conversion with saturation:
  - r3 = min(7, (r+16)>>5);
  - g3 = min(7, (g+16)>>5);
  - b2 = min(3, (b+32)>>6);
  - intermediate sums are 9-bit.
- Undefined: plain truncation to MSBs as above.
- Latency is unchanged (1 cycle) in both builds.

Test Plan:
1. Reset, arm, then a full 640x480 frame with pixel = {x[7:0], y[7:0], 0x00}. Required response:
   - exactly 76800 writes at addresses 0..76799;
   - addr 321 holds the source pixel x=2, y=2, i.e. data {3'b000, 3'b000, 2'b00};
   - frameCaptured pulses once, then busy=0.
2. Constant input r=0xFF, g=0x80, b=0x7F. Required vramPX_d:
   - truncation build: 8'b111_100_01;
   - ROUND_EN build, with r=0xF0, g=0x90, b=0xA0: 8'b111_101_11.
3. continuous=1 over two frames:
   - two frameCaptured pulses, each address 0..76799 written twice;
   - busy stays 1 throughout.
4. vsync inserted after 100 active lines:
   - shortFrame=1, no pulse;
   - the next full frame completes with 76800 writes from address 0 and pulses frameCaptured;
   - shortFrame remains 1 until the next arm.
5. abort at write #5000:
   - vramPX_we=0 from the next cycle, state IDLE, no pulse.
   - A subsequent arm restarts at address 0.
6. reset_n pulsed low mid-line:
   - outputs go to zero asynchronously (before the next clk edge);
   - after release, arm without vsync -> busy=1 and no writes issued.
